// File: rtl/pulse_gen_if.sv
// Trigger/level-pulse bundle between a requester and the pulse generator.
// Master drives trig and observes the generated pulse and status; slave is the generator.
interface pulse_gen_if #(
  parameter int PEND_W = 3
);
  logic              trig;
  logic              sig;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;
  logic              done;

  modport master (
    output trig,
    input  sig, busy, pend_cnt, overflow, done
  );

  modport slave (
    input  trig,
    output sig, busy, pend_cnt, overflow, done
  );
endinterface

// File: rtl/pulse_gen.sv
// Turns one-cycle trigger requests into HIGH_CYCLES-wide pulses separated by at least
// LOW_CYCLES low cycles; requests arriving mid-pulse wait in a saturating pending counter.
module pulse_gen #(
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 2,
  parameter int MAX_PEND    = 7,
  parameter int PEND_W      = $clog2(MAX_PEND + 1)
) (
  input  logic        clk,
  input  logic        rst,
  pulse_gen_if.slave  bus
);

  localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]   H_LAST = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0]   L_LAST = PH_W'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] P_MAX  = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] P_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state_q;
  logic [PH_W-1:0]   phase_q;
  logic              sig_q;
  logic              busy_q;
  logic [PEND_W-1:0] pend_q;
  logic              overflow_q;
  logic              done_q;

  logic              end_low;
  logic              pop;
  logic              queue_req;
  logic              restart;
  logic              drop_d;
  logic [PEND_W-1:0] pend_d;

  // A trigger landing on the last LOW edge with nothing pending starts the next
  // pulse directly, so it never sits in the counter while the FSM goes idle.
  always_comb begin
    end_low   = (state_q == LOW) && (phase_q == '0);
    pop       = end_low && (pend_q != '0);
    queue_req = bus.trig && (state_q != IDLE) && !(end_low && (pend_q == '0));
    restart   = end_low && ((pend_q != '0) || bus.trig);
    pend_d    = pend_q;
    drop_d    = 1'b0;
    if (pop && !bus.trig) begin
      pend_d = pend_q - P_ONE;
    end else if (!pop && queue_req) begin
      if (pend_q == P_MAX) drop_d = 1'b1;
      else                 pend_d = pend_q + P_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      sig_q      <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= drop_d;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.trig) begin
            state_q <= HIGH;
            phase_q <= H_LAST;
            sig_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_q == '0) begin
            state_q <= LOW;
            phase_q <= L_LAST;
            sig_q   <= 1'b0;
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end
        LOW: begin
          if (phase_q != '0) begin
            phase_q <= phase_q - 1'b1;
          end else if (restart) begin
            state_q <= HIGH;
            phase_q <= H_LAST;
            sig_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          sig_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sig      = sig_q;
  assign bus.busy     = busy_q;
  assign bus.pend_cnt = pend_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: two instances (default depth and depth 2) share stimulus; a pulse
// schedule model predicts every cycle's outputs, a monitor compares them after each edge.
module tb_pulse_gen;

  localparam int H    = 3;
  localparam int L    = 2;
  localparam int P    = H + L;
  localparam int MAXA = 7;
  localparam int MAXB = 2;
  localparam int WA   = 3;
  localparam int WB   = 2;

  typedef struct {
    bit sig;
    bit busy;
    bit ovf;
    bit done;
    int pend;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
    bit   rst_n;
    int   e;
  } rec_t;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pulse_gen_if #(.PEND_W(WA)) ifa ();
  pulse_gen_if #(.PEND_W(WB)) ifb ();

  pulse_gen #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .MAX_PEND(MAXA), .PEND_W(WA)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  pulse_gen #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .MAX_PEND(MAXB), .PEND_W(WB)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  rec_t sbq[$];
  iq_t  qa;
  iq_t  qb;
  int   edge_no  = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   acc_cnt  = 0;
  int   rise_cnt = 0;

  task automatic chk(input string nm, input int e, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, e, act, exp);
    end
  endtask

  function automatic int count_after(input iq_t q, input int e);
    int n = 0;
    foreach (q[i]) if (q[i] > e) n++;
    return n;
  endfunction

  // q holds the edge at which each accepted pulse starts; everything else follows from it.
  task automatic model_edge(inout iq_t q, input int maxp, input bit t, input bit r,
                            input int e, output exp_t x, output bit acc);
    x = '{default: 0};
    acc = 1'b0;
    if (!r) begin
      q.delete();
      return;
    end
    while (q.size() > 0 && q[0] + P < e) void'(q.pop_front());
    if (t) begin
      if (q.size() == 0 || e >= q[$] + P) begin
        q.push_back(e);
        acc = 1'b1;
      end else if (count_after(q, e) < maxp) begin
        q.push_back(q[$] + P);
        acc = 1'b1;
      end else begin
        x.ovf = 1'b1;
      end
    end
    foreach (q[i]) begin
      if (q[i] <= e && e < q[i] + H) x.sig  = 1'b1;
      if (q[i] <= e && e < q[i] + P) x.busy = 1'b1;
      if (e == q[i] + P)             x.done = 1'b1;
      if (q[i] > e)                  x.pend++;
    end
    if (x.busy) x.done = 1'b0;
  endtask

  task automatic step(input bit t, input bit r);
    rec_t rec;
    bit   acc_a;
    bit   acc_b;
    @(negedge clk);
    rst      = r;
    ifa.trig = t;
    ifb.trig = t;
    model_edge(qa, MAXA, t, r, edge_no, rec.a, acc_a);
    model_edge(qb, MAXB, t, r, edge_no, rec.b, acc_b);
    if (acc_a) acc_cnt++;
    rec.rst_n = r;
    rec.e     = edge_no;
    sbq.push_back(rec);
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic trig_run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
  endtask

  // Monitor: scoreboard compare plus an edge detector / run-length watch on dut_a.sig.
  bit prev_sig = 1'b0;
  bit gap_valid = 1'b0;
  int hi_run = 0;
  int lo_run = 0;

  always @(posedge clk) begin : mon
    rec_t r;
    #1;
    if (sbq.size() > 0) begin
      r = sbq.pop_front();
      chk("a.sig",      r.e, int'(ifa.sig),      int'(r.a.sig));
      chk("a.busy",     r.e, int'(ifa.busy),     int'(r.a.busy));
      chk("a.pend_cnt", r.e, int'(ifa.pend_cnt), r.a.pend);
      chk("a.overflow", r.e, int'(ifa.overflow), int'(r.a.ovf));
      chk("a.done",     r.e, int'(ifa.done),     int'(r.a.done));
      chk("b.sig",      r.e, int'(ifb.sig),      int'(r.b.sig));
      chk("b.busy",     r.e, int'(ifb.busy),     int'(r.b.busy));
      chk("b.pend_cnt", r.e, int'(ifb.pend_cnt), r.b.pend);
      chk("b.overflow", r.e, int'(ifb.overflow), int'(r.b.ovf));
      chk("b.done",     r.e, int'(ifb.done),     int'(r.b.done));
      if (!r.rst_n) begin
        prev_sig  = 1'b0;
        gap_valid = 1'b0;
        hi_run    = 0;
        lo_run    = 0;
      end else if (ifa.sig) begin
        if (!prev_sig) begin
          rise_cnt++;
          if (gap_valid) chk("low_gap_ge_L", r.e, int'(lo_run >= L), 1);
        end
        hi_run++;
        lo_run   = 0;
        prev_sig = 1'b1;
      end else begin
        if (prev_sig) begin
          chk("high_run_le_H", r.e, int'(hi_run <= H), 1);
          gap_valid = 1'b1;
        end
        hi_run   = 0;
        lo_run++;
        prev_sig = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    ifa.trig = 1'b0;
    ifb.trig = 1'b0;
    // Reset for one cycle, then a single trigger.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    idle(12);
    // Three back-to-back triggers from idle.
    trig_run(3);
    idle(20);
    // Five back-to-back triggers: depth-2 instance drops two.
    trig_run(5);
    idle(30);
    // Saturate the default instance and keep triggering across pop edges.
    trig_run(14);
    idle(50);
    // Reset during the second HIGH cycle of a queued pulse with three pending.
    trig_run(5);
    idle(2);
    step(1'b0, 1'b0);
    idle(15);
    // Random traffic; rising edges on sig must equal accepted triggers.
    acc_cnt  = 0;
    rise_cnt = 0;
    for (int i = 0; i < 25; i++) step(1'($urandom_range(0, 1)), 1'b1);
    idle(60);
    @(negedge clk);
    @(negedge clk);
    chk("rises_vs_accepted", edge_no, rise_cnt, acc_cnt);
    chk("scoreboard_drained", edge_no, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Transmit-side counterpart of the edge detector.
- Converts one-cycle trigger requests into clean, fixed-width high pulses on a level line `sig`, with a guaranteed low gap between pulses, so a downstream rising-edge detector sees exactly one rising edge per accepted trigger.
- Triggers arriving while a pulse is in flight are queued in a saturating pending counter.

Parameters:
- HIGH_CYCLES, 3, cycles `sig` stays high per pulse (must be >= 1).
- LOW_CYCLES, 2, minimum cycles `sig` stays low after each pulse before the next may start (must be >= 1).
- MAX_PEND, 7, maximum number of queued triggers (must be >= 1).
- PEND_W, $clog2(MAX_PEND+1), width of the pending count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next clk rising edge).
- trig  in  1  pulse request, sampled every cycle; each sampled 1 is one request.
- sig  out  1  generated level output, registered.
- busy  out  1  high whenever state != IDLE, registered.
- pend_cnt  out  PEND_W  queued requests not yet started.
- overflow  out  1  one-cycle pulse when a request is dropped.
- done  out  1  one-cycle pulse when the generator returns to IDLE.

Behaviour:
- Reset (rst==0 at edge):
  - state=IDLE, sig=0, busy=0, pend_cnt=0, overflow=0, done=0, phase counter=0.
  - Reset mid-pulse aborts the pulse; `sig` is 0 after that edge; pending requests are discarded.
  - `trig` is ignored during reset.
- FSM states IDLE, HIGH, LOW; phase counter counts down within HIGH/LOW.
- IDLE:
  - trig=1 at edge k → HIGH, sig=1 after edge k (1-cycle latency); request not added to pend_cnt.
  - trig=0 → stay IDLE.
- HIGH:
  - sig=1 for exactly HIGH_CYCLES cycles (after edges k .. k+HIGH_CYCLES-1).
  - At edge k+HIGH_CYCLES → LOW, sig=0.
- LOW:
  - sig=0 for exactly LOW_CYCLES cycles.
  - At the edge ending LOW, if pend_cnt>0: → HIGH, sig=1, pend_cnt decremented (pop).
  - Otherwise → IDLE with done=1 for that one cycle.
  - Back-to-back pulses therefore have period HIGH_CYCLES+LOW_CYCLES. Defaults: 3 high, 2 low, period 5.
- Queueing (state HIGH or LOW, or the IDLE→HIGH edge excluded as above):
  - trig=1 with no pop: pend_cnt+1 if pend_cnt<MAX_PEND; else request dropped and overflow=1 for one cycle, pend_cnt unchanged.
  - trig=1 coinciding with a pop: pend_cnt unchanged. Net zero, never overflows, even at MAX_PEND.
  - trig=0 with a pop: pend_cnt-1.
- done and overflow are never asserted for more than one consecutive cycle per event. done never coincides with busy=1 in the same cycle.
- Invariant: the number of rising edges on sig equals the number of accepted triggers (sampled trig=1 minus overflow pulses), absent reset.
- sig is never high for more than HIGH_CYCLES consecutive cycles. It is never low for fewer than LOW_CYCLES cycles between pulses.

Test Plan:
1. Defaults; rst=0 for 1 cycle, then a single trig pulse at edge 3 → sig=1 after edges 3,4,5; sig=0 from edge 6; busy 1 after edges 3–7; done=1 after edge 8; pend_cnt stays 0.
2. trig held high for 3 cycles from IDLE (edges 3,4,5) → pend_cnt goes 1,2; pulses start after edges 3, 8, 13; done after edge 18; exactly 3 rising edges on sig.
3. MAX_PEND=2; 5 consecutive trig cycles from IDLE → first starts, next two queue (pend_cnt=2), remaining two each give overflow=1; total 3 pulses.
4. pend_cnt=MAX_PEND with trig=1 on the pop edge → pend_cnt unchanged, overflow=0, next pulse starts.
5. rst=0 during second cycle of HIGH with pend_cnt=3 → after that edge sig=0, busy=0, pend_cnt=0, done=0; no further pulses.
6. Random trig (`$urandom_range(0,1)`) for 25 cycles, sig looped into an edge detector → detector pulse count == accepted-trigger count; no sig high run >3, no low gap <2.
